// File: rtl/dcache_snoop_agent.sv
// dcache_snoop_agent
// Cache-side MSI snoop responder placed between the L1 dcache and the
// coherence controller. It looks up snooped blocks through the array snoop
// port, supplies Modified blocks as two bus beats, and downgrades or
// invalidates the block's coherence state. While idle, the dcache's own bus
// requests pass straight through.
//
// Flattened array port layout:
//   snp_tag  : way w tag  at [w*TW +: TW]
//   snp_data : way w word k at [(w*2+k)*32 +: 32]
module dcache_snoop_agent #(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  // coherence controller snoop channel
  input  logic                   ccwait,
  input  logic                   ccinv,
  input  logic [31:0]            ccsnoopaddr,
  input  logic                   dwait,
  // dcache array snoop port
  output logic [$clog2(SETS)-1:0] snp_index,
  input  logic [WAYS*(32-$clog2(SETS)-3)-1:0] snp_tag,
  input  logic [WAYS-1:0]        snp_valid,
  input  logic [WAYS-1:0]        snp_dirty,
  input  logic [WAYS*64-1:0]     snp_data,
  output logic                   snp_upd,
  output logic                   snp_upd_way,
  output logic                   snp_upd_valid,
  output logic                   snp_upd_dirty,
  output logic                   snoop_busy,
  // dcache request side
  input  logic                   c_dREN,
  input  logic                   c_dWEN,
  input  logic                   c_cctrans,
  input  logic                   c_ccwrite,
  input  logic [31:0]            c_daddr,
  input  logic [31:0]            c_dstore,
  // controller request side
  output logic                   dREN,
  output logic                   dWEN,
  output logic                   cctrans,
  output logic                   ccwrite,
  output logic [31:0]            daddr,
  output logic [31:0]            dstore
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - IW - 3;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] SUP0   = 3'd2;
  localparam logic [2:0] SUP1   = 3'd3;
  localparam logic [2:0] FIN    = 3'd4;
  localparam logic [2:0] INVL   = 3'd5;
  localparam logic [2:0] WREL   = 3'd6;

  logic [2:0]    state_r, state_nxt_s;
  logic [TW-1:0] tag_r;
  logic [IW-1:0] idx_r;
  logic          inv_r;
  logic          way_r;
  logic          upd_r, upd_way_r, upd_valid_r, upd_dirty_r;
  logic          upd_nxt_s, upd_way_nxt_s, upd_valid_nxt_s, upd_dirty_nxt_s;
  logic          addr_ld_s;
  logic          hit0_s, hit1_s, hit_s, hit_way_s, hit_dirty_s;
  logic [31:0]   sup_word_s;

  // Select one 32-bit word of the snooped block by way and word offset.
  function automatic logic [31:0] pick_word(input logic [WAYS*64-1:0] data,
                                            input logic way, input logic word);
    logic [31:0] w;
    case ({way, word})
      2'b00:   w = data[31:0];
      2'b01:   w = data[63:32];
      2'b10:   w = data[95:64];
      2'b11:   w = data[127:96];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign snp_index     = idx_r;
  assign snp_upd       = upd_r;
  assign snp_upd_way   = upd_way_r;
  assign snp_upd_valid = upd_valid_r;
  assign snp_upd_dirty = upd_dirty_r;
  assign snoop_busy    = (state_r != IDLE);

  // Tag compare against both ways; way 0 wins when both hit.
  always_comb begin
    hit0_s      = snp_valid[0] && (snp_tag[TW-1:0] == tag_r);
    hit1_s      = snp_valid[1] && (snp_tag[2*TW-1:TW] == tag_r);
    hit_s       = hit0_s || hit1_s;
    hit_way_s   = !hit0_s;
    hit_dirty_s = hit_way_s ? snp_dirty[1] : snp_dirty[0];
  end

  // Next-state and state-update decisions of the snoop FSM.
  always_comb begin
    state_nxt_s     = state_r;
    addr_ld_s       = 1'b0;
    upd_nxt_s       = 1'b0;
    upd_way_nxt_s   = 1'b0;
    upd_valid_nxt_s = 1'b0;
    upd_dirty_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ccwait) begin
          addr_ld_s   = 1'b1;
          state_nxt_s = LOOKUP;
        end else if (ccinv) begin
          addr_ld_s   = 1'b1;
          state_nxt_s = INVL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s && hit_dirty_s) begin
          state_nxt_s = SUP0;
        end else if (hit_s && ccinv) begin
          upd_nxt_s     = 1'b1;
          upd_way_nxt_s = hit_way_s;
          state_nxt_s   = WREL;
        end else begin
          state_nxt_s = WREL;
        end
      end
      SUP0: begin
        if (!dwait) begin
          state_nxt_s = SUP1;
        end else begin
          state_nxt_s = SUP0;
        end
      end
      SUP1: begin
        // The FIN-cycle state write is prepared here so it is registered.
        if (!dwait) begin
          upd_nxt_s       = 1'b1;
          upd_way_nxt_s   = way_r;
          upd_valid_nxt_s = !inv_r;
          state_nxt_s     = FIN;
        end else begin
          state_nxt_s = SUP1;
        end
      end
      FIN: begin
        if (ccwait) begin
          state_nxt_s = WREL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INVL: begin
        if (hit_s) begin
          upd_nxt_s     = 1'b1;
          upd_way_nxt_s = hit_way_s;
        end else begin
          upd_nxt_s = 1'b0;
        end
        state_nxt_s = IDLE;
      end
      WREL: begin
        if (!ccwait) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WREL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, latched snoop context and registered array update strobe.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      tag_r       <= '0;
      idx_r       <= '0;
      inv_r       <= 1'b0;
      way_r       <= 1'b0;
      upd_r       <= 1'b0;
      upd_way_r   <= 1'b0;
      upd_valid_r <= 1'b0;
      upd_dirty_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      upd_r       <= upd_nxt_s;
      upd_way_r   <= upd_way_nxt_s;
      upd_valid_r <= upd_valid_nxt_s;
      upd_dirty_r <= upd_dirty_nxt_s;
      if (addr_ld_s) begin
        tag_r <= ccsnoopaddr[31:IW+3];
        idx_r <= ccsnoopaddr[IW+2:3];
      end
      if (state_r == LOOKUP) begin
        inv_r <= ccinv;
        way_r <= hit_way_s;
      end
    end
  end

  assign sup_word_s = pick_word(snp_data, way_r, (state_r == SUP1));

  // Bus mux: supply beats during SUP0/SUP1, quiet in FIN, else pass-through.
  always_comb begin
    dREN    = c_dREN;
    dWEN    = c_dWEN;
    cctrans = c_cctrans;
    ccwrite = c_ccwrite;
    daddr   = c_daddr;
    dstore  = c_dstore;
    case (state_r)
      SUP0, SUP1: begin
        dREN    = 1'b0;
        dWEN    = 1'b0;
        cctrans = 1'b1;
        ccwrite = 1'b0;
        daddr   = {tag_r, idx_r, (state_r == SUP1), 2'b00};
        dstore  = sup_word_s;
      end
      FIN: begin
        dREN    = 1'b0;
        dWEN    = 1'b0;
        cctrans = 1'b0;
        ccwrite = 1'b0;
        daddr   = 32'h0000_0000;
        dstore  = 32'h0000_0000;
      end
      default: begin
        dREN    = c_dREN;
        dWEN    = c_dWEN;
        cctrans = c_cctrans;
        ccwrite = c_ccwrite;
        daddr   = c_daddr;
        dstore  = c_dstore;
      end
    endcase
  end

endmodule

// File: doc/dcache_snoop_agent.md
# dcache_snoop_agent

- Cache-side end of the MSI coherence protocol, one instance per core between the L1 dcache and the coherence controller.
- Answers snoops from the controller by looking up the dcache arrays, and supplies a Modified block as two words.
- Updates the block's coherence state: M→S on a read snoop, M/S→I on an invalidating snoop.
- When idle, passes the dcache's own bus requests straight through.

## Interface
Parameters:
- SETS, 8, number of sets (index width = log2(SETS) = 3)
- WAYS, 2, associativity (fixed at 2)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- ccwait  in  1  snoop request from controller
- ccinv  in  1  invalidate qualifier; also a standalone invalidate when ccwait=0
- ccsnoopaddr  in  32  snooped address
- dwait  in  1  bus wait; low = current word accepted
- snp_index  out  3  set index driven to array snoop read port
- snp_tag  in  2×26  tags of both ways at snp_index
- snp_valid, snp_dirty  in  2 each  per-way state bits (valid&dirty = M, valid&~dirty = S)
- snp_data  in  2×2×32  [way][word] block data
- snp_upd  out  1  one-cycle state write strobe
- snp_upd_way  out  1  way to update
- snp_upd_valid, snp_upd_dirty  out  1 each  new state bits
- snoop_busy  out  1  dcache must stall array writes and hold its FSM while high
- c_dREN, c_dWEN, c_cctrans, c_ccwrite  in  1 each  dcache request signals
- c_daddr, c_dstore  in  32 each  dcache request signals
- dREN, dWEN, cctrans, ccwrite  out  1 each  to controller
- daddr, dstore  out  32 each  to controller

## Operation
- Address split: tag [31:6], index [5:3], word [2], byte [1:0].
- States:
  - IDLE: pass-through; all c_* signals copied to bus outputs, snoop_busy=0.
    - ccwait=1 → register ccsnoopaddr, go LOOKUP.
    - ccwait=0 & ccinv=1 → register address, go INVL.
  - LOOKUP: snp_index = latched index; register ccinv.
    - Hit way w = snp_valid[w] & tag match (way 0 wins if both match).
    - Hit & dirty → SUP0.
    - Hit & clean & ccinv → one-cycle update (valid=0, dirty=0), go WREL.
    - Otherwise → WREL.
  - SUP0: drive daddr = {tag, index, 3'b000}, dstore = snp_data[w][0], cctrans=1, ccwrite=0, dREN=dWEN=0. When dwait=0, go SUP1.
  - SUP1: daddr = {tag, index, 3'b100}, dstore = snp_data[w][1], cctrans=1. When dwait=0, go FIN.
  - FIN: one-cycle update of way w.
    - Latched ccinv=1 → valid=0, dirty=0 (M→I, memory not written).
    - Latched ccinv=0 → valid=1, dirty=0 (M→S).
    - Then go WREL if ccwait=1, else IDLE.
  - INVL: lookup; on hit (any state) update valid=0, dirty=0; go IDLE.
  - WREL: outputs pass-through but snoop_busy=1; go IDLE when ccwait=0.
- snoop_busy = 1 in every state except IDLE.
- In SUP0/SUP1/FIN the c_* inputs are ignored. The dcache is stalled, so no request is lost.
- dwait while in IDLE/WREL belongs to the dcache's own transaction and is not interpreted.

## Timing
- Reset values: FSM=IDLE, snp_upd=0, snoop_busy=0, latched address/ccinv=0. Bus outputs equal c_* (combinational pass-through).
- Reset mid-supply aborts to IDLE with no state update.
- Snoop latency: ccwait high in cycle 0 → LOOKUP in cycle 1 → cctrans=1 with word 0 valid on daddr/dstore in cycle 2.
  - The controller samples cctrans in the third ccwait cycle, so this latency is fixed; no extra stage is allowed.
- Supply handshake:
  - Word 0 is held until the cycle dwait=0.
  - Word 1 appears the following cycle and is held until the next dwait=0.
  - Any number of dwait=1 cycles is legal before and between the beats.
- State write happens exactly once per snoop, in FIN (supply) or in the cycle after LOOKUP/INVL (clean invalidate). snp_upd is never high for more than one cycle.
- ccwait dropping during LOOKUP on a clean hit has no effect. ccwait is never lowered by the controller mid-supply.

## Test plan
- Read snoop, M hit:
  - Setup: way 1 at 0x0000_0048 is M, data {0xAAAA0001, 0xBBBB0002}; ccwait=1, ccinv=0.
  - Expect: cctrans=1 on cycle 2 with daddr=0x48, dstore=0xAAAA0001.
  - After dwait=0: daddr=0x4C, dstore=0xBBBB0002.
  - FIN: snp_upd, way 1, valid=1, dirty=0.
- Write snoop, M hit with ccinv=1:
  - Expect: same two beats, 3 dwait-high cycles inserted before beat 1.
  - FIN: update valid=0, dirty=0.
- S hit:
  - ccinv=1 → single update valid=0, cctrans stays 0.
  - ccinv=0 → no snp_upd, cctrans stays 0.
- Miss (tag 0x1234 absent): cctrans=0, no snp_upd, snoop_busy high until ccwait falls, then bus = c_* values.
- Standalone ccinv pulse (ccwait=0) to an S block: invalidated within 2 cycles, returns to IDLE.
- nRST asserted during SUP1: outputs return to pass-through immediately, no snp_upd. Next snoop behaves normally.
